// File: rtl/poly_square_mixer.sv
// poly_square_mixer: VOICES gated square oscillators stepped per sample tick,
// summed sequentially into one saturated signed sample on a valid/ready port.
module poly_square_mixer #(
  parameter int VOICES   = 4,
  parameter int PERIOD_W = 16,
  parameter int AMP_W    = 8,
  parameter int SAMPLE_W = 16,
  parameter int SHIFT    = 6
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         sample_tick_i,
  input  logic [VOICES*PERIOD_W-1:0]   voice_period_i,
  input  logic [VOICES*AMP_W-1:0]      voice_amp_i,
  input  logic [VOICES-1:0]            voice_gate_i,
  output logic signed [SAMPLE_W-1:0]   sample_out_o,
  output logic                         sample_valid_o,
  input  logic                         sample_ready_i,
  output logic                         overrun_o
);
  localparam int ACC_W = SAMPLE_W + $clog2(VOICES) + 1;
  localparam int IDX_W = VOICES > 1 ? $clog2(VOICES) : 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                      state_q, state_d;
  logic [PERIOD_W-1:0]         cnt_q [VOICES];
  logic [PERIOD_W-1:0]         cnt_d [VOICES];
  logic signed [SAMPLE_W-1:0]  contrib [VOICES];
  logic signed [SAMPLE_W-1:0]  snap_q [VOICES];
  logic signed [SAMPLE_W-1:0]  snap_d [VOICES];
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [SAMPLE_W-1:0]  out_q, out_d;
  logic                        valid_q, valid_d;
  logic                        overrun_q, overrun_d;

  // Level is taken from the pre-update count so a fresh voice starts high.
  genvar v;
  for (v = 0; v < VOICES; v++) begin : g_voice
    logic [PERIOD_W-1:0]        per;
    logic signed [SAMPLE_W-1:0] mag;
    logic                       live;
    assign per          = voice_period_i[v*PERIOD_W +: PERIOD_W];
    assign mag          = SAMPLE_W'(voice_amp_i[v*AMP_W +: AMP_W]) << SHIFT;
    assign live         = voice_gate_i[v] && per >= PERIOD_W'(2);
    assign cnt_d[v]     = (!live || cnt_q[v] >= per - 1'b1) ? '0 : cnt_q[v] + 1'b1;
    assign contrib[v]   = !live ? '0 : (cnt_q[v] < (per >> 1)) ? mag : -mag;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    out_d     = out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q | (sample_tick_i && state_q != IDLE);
    if (state_q == IDLE) begin
      if (sample_tick_i) begin
        snap_d  = contrib;
        acc_d   = '0;
        idx_d   = '0;
        state_d = ACCUM;
      end
    end else if (state_q == ACCUM) begin
      acc_d   = acc_q + ACC_W'(snap_q[idx_q]);
      idx_d   = idx_q + 1'b1;
      state_d = idx_q == IDX_W'(VOICES - 1) ? OUT : ACCUM;
    end else if (!valid_q) begin
      out_d   = acc_q > SAT_HI ? SAT_HI[SAMPLE_W-1:0] :
                acc_q < SAT_LO ? SAT_LO[SAMPLE_W-1:0] : acc_q[SAMPLE_W-1:0];
      valid_d = 1'b1;
    end else if (sample_ready_i) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '{default: '0};
      snap_q    <= '{default: '0};
      acc_q     <= '0;
      idx_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (sample_tick_i) cnt_q <= cnt_d;
      snap_q    <= snap_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out_o   = out_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;
endmodule

// File: tb/tb_poly_square_mixer.sv
// tb_poly_square_mixer: directed scenarios for the 4-voice mixer with
// hand-computed samples (full-scale voice = 255<<6 = 16320).
module tb_poly_square_mixer;
  logic               clk = 0;
  logic               reset = 0;
  logic               tick = 0;
  logic [63:0]        period = '0;
  logic [31:0]        amp = '0;
  logic [3:0]         gate = '0;
  logic signed [15:0] sample_out;
  logic               valid;
  logic               ready = 1;
  logic               overrun;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic signed [15:0] FULL = 16'sd16320;
  localparam logic signed [15:0] NFULL = -16'sd16320;

  poly_square_mixer dut (
    .clk_i(clk), .reset_i(reset), .sample_tick_i(tick),
    .voice_period_i(period), .voice_amp_i(amp), .voice_gate_i(gate),
    .sample_out_o(sample_out), .sample_valid_o(valid),
    .sample_ready_i(ready), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  // Called at a negedge; pulses tick for one cycle and waits for valid.
  task automatic get_sample(output logic signed [15:0] s, output int lat);
    tick = 1;
    @(negedge clk);
    tick = 0;
    lat = 1;
    while (!valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s = sample_out;
  endtask

  task automatic idle_gap();
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (sample_out !== 16'sd0 || valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%0d valid=%b overrun=%b, required 0/0/0", sample_out, valid, overrun);
    end
  endtask

  task automatic test_single_voice();
    logic signed [15:0] s, e;
    int lat;
    apply_reset();
    period = '0; amp = '0; gate = 4'b0001;
    period[15:0] = 16'd4; amp[7:0] = 8'd255;
    ready = 1;
    for (int i = 0; i < 8; i++) begin
      get_sample(s, lat);
      e = (i % 4 < 2) ? FULL : NFULL;
      n_checks++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL single_sample[%0d]: got %0d, required %0d", i, s, e);
      end
      n_checks++;
      if (lat !== 6) begin
        n_fail++;
        $display("FAIL single_latency[%0d]: got %0d, required 6", i, lat);
      end
      idle_gap();
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL single_overrun: got %b, required 0", overrun);
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] s, e;
    int lat;
    apply_reset();
    period = {4{16'd8}}; amp = {4{8'd255}}; gate = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      get_sample(s, lat);
      e = (i < 4) ? 16'sd32767 : -16'sd32768;
      n_checks++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got %0d, required %0d", i, s, e);
      end
      idle_gap();
    end
  endtask

  task automatic test_silent();
    logic signed [15:0] s;
    int lat;
    apply_reset();
    period = '0; amp = '0; gate = 4'b0000;
    period[15:0] = 16'd4; amp[7:0] = 8'd255;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        gate = 4'b0001;
        period[15:0] = 16'd1;
      end
      get_sample(s, lat);
      n_checks++;
      if (s !== 16'sd0 || dut.cnt_q[0] !== 16'd0) begin
        n_fail++;
        $display("FAIL silent[%0d]: sample %0d cnt %0d, required 0 and 0", i, s, dut.cnt_q[0]);
      end
      idle_gap();
    end
    period[15:0] = 16'd4;
    get_sample(s, lat);
    n_checks++;
    if (s !== FULL) begin
      n_fail++;
      $display("FAIL silent_gate_on: got %0d, required %0d", s, FULL);
    end
    idle_gap();
  endtask

  task automatic test_period_shrink();
    logic signed [15:0] s, e;
    int lat;
    apply_reset();
    period = '0; amp = '0; gate = 4'b0001;
    period[15:0] = 16'd10; amp[7:0] = 8'd255;
    for (int i = 0; i < 7; i++) begin
      get_sample(s, lat);
      e = (i < 5) ? FULL : NFULL;
      n_checks++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL shrink_p10[%0d]: got %0d, required %0d", i, s, e);
      end
      idle_gap();
    end
    n_checks++;
    if (dut.cnt_q[0] !== 16'd7) begin
      n_fail++;
      $display("FAIL shrink_cnt: got %0d, required 7", dut.cnt_q[0]);
    end
    period[15:0] = 16'd4;
    for (int i = 0; i < 5; i++) begin
      get_sample(s, lat);
      e = (i == 0 || i == 3 || i == 4) ? NFULL : FULL;
      n_checks++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL shrink_p4[%0d]: got %0d, required %0d", i, s, e);
      end
      idle_gap();
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] s;
    int lat;
    apply_reset();
    period = '0; amp = '0; gate = 4'b0001;
    period[15:0] = 16'd4; amp[7:0] = 8'd255;
    ready = 0;
    get_sample(s, lat);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tick = 1;
      @(negedge clk);
      tick = 0;
      repeat (3) @(negedge clk);
    end
    n_checks++;
    if (sample_out !== FULL || valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_hold: out=%0d valid=%b overrun=%b, required %0d/1/1", sample_out, valid, overrun, FULL);
    end
    ready = 1;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || sample_out !== FULL) begin
      n_fail++;
      $display("FAIL backpressure_release: valid=%b out=%0d, required 0/%0d", valid, sample_out, FULL);
    end
    idle_gap();
    get_sample(s, lat);
    n_checks++;
    if (s !== NFULL || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_next: out=%0d overrun=%b, required %0d/1", s, overrun, NFULL);
    end
    idle_gap();
  endtask

  task automatic test_reset_mid_accum();
    logic signed [15:0] s;
    int lat;
    tick = 1;
    @(negedge clk);
    tick = 0;
    @(negedge clk);
    reset = 1;
    #1;
    n_checks++;
    if (valid !== 1'b0 || sample_out !== 16'sd0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_accum: valid=%b out=%0d overrun=%b, required 0/0/0", valid, sample_out, overrun);
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    get_sample(s, lat);
    n_checks++;
    if (s !== FULL || lat !== 6) begin
      n_fail++;
      $display("FAIL reset_recover: out=%0d lat=%0d, required %0d/6", s, lat, FULL);
    end
    idle_gap();
  endtask

  initial begin
    test_reset();
    test_single_voice();
    test_saturation();
    test_silent();
    test_period_shrink();
    test_back_to_back();
    test_reset_mid_accum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
